// File: rtl/clock_seq_pkg.sv
// rtl/clock_seq_pkg.sv - shared state encoding and default timing constants for the clock sequencer
// Contents:
//   seq_state_e        7-state sequencer encoding (3 bits)
//   DEF_* constants    default cycle counts, retry budget and counter width
package clock_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST  = 3'd0,
        ST_PLL_WAIT = 3'd1,
        ST_DCM_RST  = 3'd2,
        ST_DCM_WAIT = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_RUN      = 3'd5,
        ST_FAIL     = 3'd6
    } seq_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 33000;
    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous level
// Ports:
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low reset, both flops clear to 0
//   d      in  asynchronous level
//   q      out level synchronized to clk, two cycles of latency
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clock_sequencer.sv
// rtl/clock_sequencer.sv - reset/lock sequencer for the PLL -> DCM chain producing the 48 MHz clock
// Ports:
//   clk_33             in  free-running board clock, the only clock used here
//   rst_n              in  asynchronous active-low reset
//   pll_locked         in  PLL LOCKED (asynchronous)
//   dcm_locked         in  DCM LOCKED (asynchronous)
//   dcm_clkin_stopped  in  DCM STATUS[1] (asynchronous)
//   restart            in  synchronous single-cycle restart request
//   pll_rst            out PLL reset, active-high
//   dcm_rst            out DCM reset, active-high
//   clk_ready          out 48 MHz clock is stable
//   retries            out consecutive lock timeouts so far
//   fail               out retry budget exhausted
module clock_sequencer
    import clock_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk_33,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       dcm_locked,
    input  logic       dcm_clkin_stopped,
    input  logic       restart,
    output logic       pll_rst,
    output logic       dcm_rst,
    output logic       clk_ready,
    output logic [1:0] retries,
    output logic       fail
);

    // A state with an N-cycle count exits on the edge where the counter reads N-1.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRIES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    logic       pll_sync;
    logic       dcm_sync;
    logic       stop_sync;
    logic       pll_ok;
    logic       dcm_ok;

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       retries_d;
    logic             enter;
    logic             timeout;

    sync2 u_sync_pll  (.clk(clk_33), .rst_n(rst_n), .d(pll_locked),        .q(pll_sync));
    sync2 u_sync_dcm  (.clk(clk_33), .rst_n(rst_n), .d(dcm_locked),        .q(dcm_sync));
    sync2 u_sync_stop (.clk(clk_33), .rst_n(rst_n), .d(dcm_clkin_stopped), .q(stop_sync));

    // A stopped DCM input clock makes a stale LOCKED meaningless.
    assign pll_ok = pll_sync;
    assign dcm_ok = dcm_sync && !stop_sync;

    // Priority: restart, PLL loss, DCM loss, lock detected, timeout.
    // 'enter' flags every state entry, including re-entry of the same state,
    // so the cycle counter restarts from zero.
    always_comb begin
        state_d   = state_q;
        retries_d = retries;
        enter     = 1'b0;
        timeout   = 1'b0;
        if (restart) begin
            state_d   = ST_PLL_RST;
            retries_d = '0;
            enter     = 1'b1;
        end else if (!pll_ok && (state_q inside {ST_DCM_RST, ST_DCM_WAIT, ST_SETTLE, ST_RUN})) begin
            state_d = ST_PLL_RST;
            enter   = 1'b1;
        end else if (!dcm_ok && (state_q inside {ST_SETTLE, ST_RUN})) begin
            state_d = ST_DCM_RST;
            enter   = 1'b1;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_PLL_WAIT;
                        enter   = 1'b1;
                    end
                end
                ST_PLL_WAIT: begin
                    if (pll_ok) begin
                        state_d = ST_DCM_RST;
                        enter   = 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        timeout = 1'b1;
                    end
                end
                ST_DCM_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_DCM_WAIT;
                        enter   = 1'b1;
                    end
                end
                ST_DCM_WAIT: begin
                    if (dcm_ok) begin
                        state_d = ST_SETTLE;
                        enter   = 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        timeout = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d   = ST_RUN;
                        retries_d = '0;
                        enter     = 1'b1;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_PLL_RST;
                    enter   = 1'b1;
                end
            endcase

            if (timeout) begin
                enter = 1'b1;
                if (retries == RETRY_LAST) begin
                    state_d   = ST_FAIL;
                    retries_d = RETRY_MAX;
                end else begin
                    state_d   = ST_PLL_RST;
                    retries_d = retries + 2'd1;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge
    // as the state register and come straight from flops.
    always_ff @(posedge clk_33 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            retries   <= '0;
            pll_rst   <= 1'b1;
            dcm_rst   <= 1'b1;
            clk_ready <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q <= state_d;
            retries <= retries_d;
            if (enter) begin
                cnt_q <= '0;
            end else if (state_q != ST_RUN && state_q != ST_FAIL) begin
                cnt_q <= cnt_q + 1'b1;
            end
            pll_rst   <= (state_d inside {ST_PLL_RST, ST_FAIL});
            dcm_rst   <= (state_d inside {ST_PLL_RST, ST_PLL_WAIT, ST_DCM_RST, ST_FAIL});
            clk_ready <= (state_d == ST_RUN);
            fail      <= (state_d == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_clock_sequencer.sv
// tb/tb_clock_sequencer.sv - scoreboard bench for clock_sequencer with a phase/elapsed-time reference model
module tb_clock_sequencer;

    localparam int RST  = 16;
    localparam int LT   = 300;
    localparam int SET  = 1024;
    localparam int MAXR = 3;

    localparam int P_PLL_RST  = 0;
    localparam int P_PLL_WAIT = 1;
    localparam int P_DCM_RST  = 2;
    localparam int P_DCM_WAIT = 3;
    localparam int P_SETTLE   = 4;
    localparam int P_RUN      = 5;
    localparam int P_FAIL     = 6;

    logic       clk_33 = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       dcm_locked = 1'b0;
    logic       dcm_clkin_stopped = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       dcm_rst;
    logic       clk_ready;
    logic [1:0] retries;
    logic       fail;

    clock_sequencer #(
        .RST_CYCLES(RST), .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SET),
        .MAX_RETRIES(MAXR), .CNT_W(16)
    ) dut (
        .clk_33(clk_33), .rst_n(rst_n), .pll_locked(pll_locked),
        .dcm_locked(dcm_locked), .dcm_clkin_stopped(dcm_clkin_stopped),
        .restart(restart), .pll_rst(pll_rst), .dcm_rst(dcm_rst),
        .clk_ready(clk_ready), .retries(retries), .fail(fail)
    );

    always #5 clk_33 = ~clk_33;

    typedef struct {
        int edge_n;
        bit pll_rst;
        bit dcm_rst;
        bit clk_ready;
        bit fail;
        int retries;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: current phase, the edge it was entered on, edges since
    // reset release, and the full history of sampled inputs (index 0 = edge 1).
    int m_phase, m_entry, m_cyc, m_retries;
    bit h_pll[$], h_dcm[$], h_stop[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t, edge %0d)", name, act, exp, $time, m_cyc);
        end
    endtask

    task automatic model_edge(input bit rs);
        int  k, el, nxt;
        bit  pok, dok, go, tmo;
        m_cyc++;
        k   = m_cyc;
        el  = k - m_entry;
        // The sequencer sees an input two edges after it was sampled.
        pok = (k >= 3) ? h_pll[k-3] : 1'b0;
        dok = (k >= 3) ? (h_dcm[k-3] && !h_stop[k-3]) : 1'b0;
        nxt = m_phase;
        go  = 1'b0;
        tmo = 1'b0;
        if (rs) begin
            nxt = P_PLL_RST; m_retries = 0; go = 1'b1;
        end else if (!pok && m_phase inside {P_DCM_RST, P_DCM_WAIT, P_SETTLE, P_RUN}) begin
            nxt = P_PLL_RST; go = 1'b1;
        end else if (!dok && m_phase inside {P_SETTLE, P_RUN}) begin
            nxt = P_DCM_RST; go = 1'b1;
        end else begin
            case (m_phase)
                P_PLL_RST:  if (el == RST) begin nxt = P_PLL_WAIT; go = 1'b1; end
                P_PLL_WAIT: if (pok) begin nxt = P_DCM_RST; go = 1'b1; end else if (el == LT) tmo = 1'b1;
                P_DCM_RST:  if (el == RST) begin nxt = P_DCM_WAIT; go = 1'b1; end
                P_DCM_WAIT: if (dok) begin nxt = P_SETTLE; go = 1'b1; end else if (el == LT) tmo = 1'b1;
                P_SETTLE:   if (el == SET) begin nxt = P_RUN; m_retries = 0; go = 1'b1; end
                default:    ;
            endcase
            if (tmo) begin
                go = 1'b1;
                if (m_retries == MAXR - 1) begin nxt = P_FAIL; m_retries = MAXR; end
                else begin nxt = P_PLL_RST; m_retries++; end
            end
        end
        if (go) begin
            m_phase = nxt;
            m_entry = k;
        end
    endtask

    task automatic cycle(input bit pl, input bit dl, input bit st, input bit rs);
        exp_t e;
        pll_locked = pl; dcm_locked = dl; dcm_clkin_stopped = st; restart = rs;
        h_pll.push_back(pl); h_dcm.push_back(dl); h_stop.push_back(st);
        model_edge(rs);
        e.edge_n    = m_cyc;
        e.pll_rst   = (m_phase inside {P_PLL_RST, P_FAIL});
        e.dcm_rst   = (m_phase inside {P_PLL_RST, P_PLL_WAIT, P_DCM_RST, P_FAIL});
        e.clk_ready = (m_phase == P_RUN);
        e.fail      = (m_phase == P_FAIL);
        e.retries   = m_retries;
        @(posedge clk_33);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic do_reset();
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_dcm_rst", dcm_rst, 1);
        chk("rst_clk_ready", clk_ready, 0);
        chk("rst_retries", retries, 0);
        chk("rst_fail", fail, 0);
        repeat (2) @(posedge clk_33);
        #1;
        rst_n = 1'b1;
        restart = 1'b0;
        m_phase = P_PLL_RST; m_entry = 0; m_cyc = 0; m_retries = 0;
        h_pll.delete(); h_dcm.delete(); h_stop.delete();
    endtask

    // Monitor: compares the DUT against the oldest pending expectation once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_33);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_pll_rst", pll_rst, e.pll_rst);
                chk("sb_dcm_rst", dcm_rst, e.dcm_rst);
                chk("sb_clk_ready", clk_ready, e.clk_ready);
                chk("sb_fail", fail, e.fail);
                chk("sb_retries", retries, e.retries);
            end
        end
    end

    initial begin
        int f, k0, e_pll, e_dcm, e_rdy, e_fail, hi_cnt, pr_hi, e_dw, reached;
        int lo_p, lo_d, lo_s;
        bit dl, rs;

        #2;
        do_reset();

        // Locks tied high from release: reset release edges.
        e_pll = -1; e_dcm = -1; e_rdy = -1;
        for (int i = 0; i < 1100; i++) begin
            cycle(1, 1, 0, 0);
            if (e_pll < 0 && !pll_rst) e_pll = m_cyc;
            if (e_dcm < 0 && !dcm_rst) e_dcm = m_cyc;
            if (e_rdy < 0 && clk_ready) e_rdy = m_cyc;
        end
        chk("t1_pll_rst_fall_edge", e_pll, RST);
        chk("t1_dcm_rst_fall_edge", e_dcm, 2 * RST + 1);
        chk("t1_clk_ready_rise_edge", e_rdy, 2 * RST + SET + 2);

        // PLL never locks: three timeouts then FAIL, then restart.
        cycle(0, 1, 0, 1);
        k0 = m_cyc;
        e_fail = -1;
        for (int i = 0; i < 3 * (RST + LT) + 20; i++) begin
            cycle(0, 1, 0, 0);
            if (m_cyc == k0 + RST + LT) chk("t2_retries_1", retries, 1);
            if (m_cyc == k0 + 2 * (RST + LT)) chk("t2_retries_2", retries, 2);
            if (e_fail < 0 && fail) e_fail = m_cyc;
        end
        chk("t2_fail_after", e_fail - k0, 3 * (RST + LT));
        chk("t2_retries_3", retries, 3);
        chk("t2_fail_pll_rst", pll_rst, 1);
        chk("t2_fail_dcm_rst", dcm_rst, 1);
        cycle(1, 1, 0, 1);
        chk("t2_restart_retries", retries, 0);
        chk("t2_restart_fail", fail, 0);
        chk("t2_restart_pll_rst", pll_rst, 1);

        // In RUN, drop the DCM lock for 5 cycles.
        for (int i = 0; i < 1100; i++) cycle(1, 1, 0, 0);
        chk("t3_in_run", clk_ready, 1);
        f = m_cyc + 1;
        hi_cnt = 0; pr_hi = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1, (i >= 5), 0, 0);
            if (m_cyc == f + 1) chk("t3_ready_still_high", clk_ready, 1);
            if (m_cyc == f + 2) chk("t3_ready_fall", clk_ready, 0);
            hi_cnt += int'(dcm_rst);
            pr_hi  += int'(pll_rst);
        end
        chk("t3_dcm_rst_pulse", hi_cnt, RST);
        chk("t3_pll_rst_quiet", pr_hi, 0);
        chk("t3_retries_kept", retries, 0);

        // In SETTLE, drop both locks together: PLL loss wins.
        f = m_cyc + 1;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0);
            if (m_cyc == f + 1) chk("t4_pll_rst_low", pll_rst, 0);
            if (m_cyc == f + 2) chk("t4_pll_rst_rise", pll_rst, 1);
        end

        // DCM lock seen exactly on the timeout cycle of DCM_WAIT.
        cycle(1, 0, 0, 1);
        dl = 1'b0; e_dw = -1; reached = 0;
        for (int i = 0; i < 2 * RST + LT + 20; i++) begin
            if (e_dw < 0 && m_phase == P_DCM_WAIT) e_dw = m_entry;
            if (e_dw >= 0 && m_cyc + 1 >= e_dw + LT - 2) dl = 1'b1;
            cycle(1, dl, 0, 0);
            if (e_dw >= 0 && m_cyc == e_dw + LT) begin
                reached = 1;
                chk("t5_no_timeout_pll_rst", pll_rst, 0);
                chk("t5_no_timeout_dcm_rst", dcm_rst, 0);
                chk("t5_retries", retries, 0);
            end
        end
        chk("t5_boundary_reached", reached, 1);

        // Asynchronous reset while in SETTLE.
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0);
        do_reset();

        // Randomized lock drops, glitches, clock-stopped events, restarts and resets.
        lo_p = 0; lo_d = 0; lo_s = 0;
        for (int i = 0; i < 25000; i++) begin
            if (lo_p == 0 && $urandom_range(0, 999) == 0)
                lo_p = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : $urandom_range(5, 700);
            if (lo_d == 0 && $urandom_range(0, 699) == 0)
                lo_d = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : $urandom_range(5, 500);
            if (lo_s == 0 && $urandom_range(0, 2999) == 0)
                lo_s = $urandom_range(1, 20);
            rs = ($urandom_range(0, 2999) == 0);
            cycle(lo_p == 0, lo_d == 0, lo_s != 0, rs);
            if (lo_p > 0) lo_p--;
            if (lo_d > 0) lo_d--;
            if (lo_s > 0) lo_s--;
            if ($urandom_range(0, 7999) == 0) do_reset();
        end

        @(negedge clk_33);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_sequencer.md
# clock_sequencer

Reset and lock sequencer for the PLL→DCM clock chain that derives the 48 MHz clock from the 33 MHz board clock. It drives the PLL and DCM reset inputs in the required order, watches their LOCKED and STATUS outputs, retries on lock timeout, restarts on lock loss and asserts `clk_ready` once the 48 MHz clock is stable. It runs entirely on the free-running `clk_33`, never on a generated clock.

## Interface
- `RST_CYCLES`, 16: cycles each reset pulse is held; minimum 4.
- `LOCK_TIMEOUT`, 33000: cycles allowed for a lock to appear (1 ms).
- `SETTLE_CYCLES`, 1024: cycles both locks must hold before `clk_ready` asserts.
- `MAX_RETRIES`, 3: consecutive timeouts tolerated before FAIL.
- `CNT_W`, 16: shared cycle-counter width; must hold all three cycle parameters.

Ports:
- `clk_33`  in  1  free-running 33 MHz board clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL LOCKED; asynchronous.
- `dcm_locked`  in  1  DCM LOCKED; asynchronous.
- `dcm_clkin_stopped`  in  1  DCM STATUS[1]; asynchronous.
- `restart`  in  1  synchronous single-cycle restart request.
- `pll_rst`  out  1  PLL reset, active-high.
- `dcm_rst`  out  1  DCM reset, active-high.
- `clk_ready`  out  1  48 MHz clock valid.
- `retries`  out  2  consecutive lock timeouts so far.
- `fail`  out  1  retry budget exhausted.

## Operation
- Async inputs pass through 2-flop synchronizers, which reset to 0. `pll_ok` = synced `pll_locked`. `dcm_ok` = synced `dcm_locked` and not synced `dcm_clkin_stopped`.
- States and their outputs (`pll_rst`/`dcm_rst`):
  - PLL_RST: 1/1.
  - PLL_WAIT: 0/1.
  - DCM_RST: 0/1.
  - DCM_WAIT: 0/0.
  - SETTLE: 0/0.
  - RUN: 0/0, `clk_ready`=1.
  - FAIL: 1/1, `fail`=1.
- Transitions:
  - PLL_RST → PLL_WAIT after `RST_CYCLES` cycles.
  - PLL_WAIT → DCM_RST when `pll_ok`. After `LOCK_TIMEOUT` cycles without lock, take the timeout path.
  - DCM_RST → DCM_WAIT after `RST_CYCLES` cycles.
  - DCM_WAIT → SETTLE when `dcm_ok`. After `LOCK_TIMEOUT` cycles without lock, take the timeout path.
  - SETTLE → RUN after `SETTLE_CYCLES` consecutive cycles with `pll_ok` && `dcm_ok`.
  - In DCM_RST, DCM_WAIT, SETTLE and RUN: `!pll_ok` → PLL_RST.
  - In SETTLE and RUN: `pll_ok` && `!dcm_ok` → DCM_RST.
- Timeout path:
  - If `retries` == `MAX_RETRIES`-1: go to FAIL and set `retries` = `MAX_RETRIES`.
  - Otherwise: `retries`+1, then go to PLL_RST.
- `retries` clears on entry to RUN. Lock loss does not count as a retry.
- FAIL is left only by `restart` or `rst_n`.
- `restart` in any state: go to PLL_RST, clear `retries` and `fail`.
- The cycle counter clears on every state entry.

## Timing
- Reset values: `pll_rst`=1, `dcm_rst`=1, `clk_ready`=0, `retries`=0, `fail`=0, state PLL_RST, counter 0.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state. They are glitch-free.
- A state with an N-cycle count is entered at edge 0 and exits at edge N.
- Input sync latency is 2 cycles, so lock loss is seen 3 edges after the input falls.
- With both locks tied high, `clk_ready` rises at edge 2·`RST_CYCLES`+`SETTLE_CYCLES`+2 after the first edge following `rst_n` release. Defaults give edge 1058.
- Same-cycle priority, highest first:
  - `restart`.
  - `!pll_ok`.
  - `!dcm_ok`.
  - Lock detected.
  - Timeout.
- A lock arriving in the timeout cycle wins over the timeout.
- `rst_n` assertion mid-sequence immediately forces all reset values.

## Structure
- `clock_seq_pkg`: state enum (7 states, 3-bit encoding) and default-parameter constants.
- Sub-module `sync2`: 2-flop synchronizer with async active-low reset. Instantiated 3×.

## Test plan
- Locks tied high, release `rst_n` → `pll_rst` falls at edge 16, `dcm_rst` falls at edge 33, `clk_ready` rises at edge 1058.
- `pll_locked` held low → PLL_RST/PLL_WAIT repeat. `retries` reads 1 then 2. `fail`=1 and both resets held high after the 3rd timeout. `restart` → `retries`=0, `fail`=0, sequence restarts.
- In RUN, drop `dcm_locked` for 5 cycles → `clk_ready` falls 3 edges after the input falls. `dcm_rst` pulses for 16 cycles. `pll_rst` stays 0. `retries` is unchanged.
- In SETTLE, drop `pll_locked` and `dcm_locked` together → state goes to PLL_RST (PLL loss wins), and `pll_rst` rises.
- In DCM_WAIT, `dcm_locked` rises so `dcm_ok` is seen exactly at cycle `LOCK_TIMEOUT` → SETTLE entered, `retries` not incremented.
- Assert `rst_n` in SETTLE → all outputs at reset values before the next edge.
